key_sched_cache: RTL and testbench

- Parametrised successor to the single-key expansion front end.
- Caches expanded round-key sets for up to NUM_SLOTS distinct cipher keys (128/192/256) in an internal round-key memory.
- Looks up each key request against the cache.
- On a miss, drives an external key-expansion engine, collects its subkeys into a victim slot and reports the slot index. The cipher datapath then reads round keys by (slot, round).

---
 rtl/key_sched_cache_if.sv | 53 +++++
 rtl/key_sched_cache.sv | 196 +++++++++++++++++++
 tb/tb_key_sched_cache.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_sched_cache_if.sv
// rtl/key_sched_cache_if.sv - request/response, expansion-engine and round-key read bundle
//
// Purpose: groups the handshake and bus signals of key_sched_cache.
// Ports (signals):
//   req_valid/req_ready/req_key/req_len         key request handshake
//   resp_valid/resp_ready/resp_slot/hit/err     lookup response handshake
//   exp_start/exp_key/exp_len                   command to expansion engine
//   exp_valid/exp_waddr/exp_subkey              subkeys returned by engine
//   rd_en/rd_slot/rd_idx/rd_data                round-key read port
// Modports: slave = cache side, master = requester/engine/datapath side.

interface key_sched_cache_if #(
  parameter int KEY_W    = 256,
  parameter int SUBKEY_W = 128,
  parameter int SLOT_W   = 2
) ();
  logic                req_valid;
  logic                req_ready;
  logic [KEY_W-1:0]    req_key;
  logic [1:0]          req_len;

  logic                resp_valid;
  logic                resp_ready;
  logic [SLOT_W-1:0]   resp_slot;
  logic                resp_hit;
  logic                resp_err;

  logic                exp_start;
  logic [KEY_W-1:0]    exp_key;
  logic [1:0]          exp_len;
  logic                exp_valid;
  logic [3:0]          exp_waddr;
  logic [SUBKEY_W-1:0] exp_subkey;

  logic                rd_en;
  logic [SLOT_W-1:0]   rd_slot;
  logic [3:0]          rd_idx;
  logic [SUBKEY_W-1:0] rd_data;

  modport slave (
    input  req_valid, req_key, req_len, resp_ready,
           exp_valid, exp_waddr, exp_subkey, rd_en, rd_slot, rd_idx,
    output req_ready, resp_valid, resp_slot, resp_hit, resp_err,
           exp_start, exp_key, exp_len, rd_data
  );

  modport master (
    output req_valid, req_key, req_len, resp_ready,
           exp_valid, exp_waddr, exp_subkey, rd_en, rd_slot, rd_idx,
    input  req_ready, resp_valid, resp_slot, resp_hit, resp_err,
           exp_start, exp_key, exp_len, rd_data
  );
endinterface

// File: rtl/key_sched_cache.sv
// rtl/key_sched_cache.sv - multi-slot cache of expanded cipher round-key sets
//
// Purpose: looks up key requests against NUM_SLOTS cached round-key sets, drives an
// external expansion engine on a miss and fills a victim slot; round keys are read
// back by (slot, round) with one cycle of latency.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   pin_i    per-slot in-use mask, pinned slots are never evicted
//   flush_i  invalidate all slots (acted on in IDLE only)
//   busy_o   state != IDLE
//   bus      key_sched_cache_if.slave (request, response, engine, read port)

module key_sched_cache #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int KEY_W     = 256,
  parameter int SUBKEY_W  = 128,
  parameter int RK_DEPTH  = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_SLOTS-1:0] pin_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  key_sched_cache_if.slave     bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_START, S_COLLECT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q;
  logic [1:0]          len_q;
  logic [NUM_SLOTS-1:0] valid_q;
  logic [SLOT_W-1:0]   rr_q, victim_q, resp_slot_q;
  logic                resp_hit_q, resp_err_q;
  logic [3:0]          cnt_q;
  logic [SUBKEY_W-1:0] rd_data_q;

  logic [KEY_W-1:0]    tag_key_q [NUM_SLOTS];
  logic [1:0]          tag_len_q [NUM_SLOTS];
  logic [SUBKEY_W-1:0] mem_q     [NUM_SLOTS][RK_DEPTH];

  // Keep only the key bits that belong to the selected length; the rest are zero
  // so tags and the engine key never carry stale low-order bits.
  function automatic logic [KEY_W-1:0] mask_key(input logic [KEY_W-1:0] k, input logic [1:0] l);
    logic [KEY_W-1:0] m;
    case (l)
      2'b01:   m = ~({KEY_W{1'b1}} >> 128);
      2'b10:   m = ~({KEY_W{1'b1}} >> 192);
      2'b11:   m = {KEY_W{1'b1}};
      default: m = '0;
    endcase
    return k & m;
  endfunction

  function automatic logic [3:0] num_subkeys(input logic [1:0] l);
    case (l)
      2'b01:   return 4'd11;
      2'b10:   return 4'd13;
      default: return 4'd15;
    endcase
  endfunction

  // Lookup: hit detection, lowest invalid slot, and first unpinned slot from rr.
  logic              hit_found, inv_found, ev_found, victim_ok;
  logic [SLOT_W-1:0] hit_idx, inv_idx, ev_idx, victim_sel, cand;

  always_comb begin
    hit_found = 1'b0;
    inv_found = 1'b0;
    ev_found  = 1'b0;
    hit_idx   = '0;
    inv_idx   = '0;
    ev_idx    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit_found && valid_q[i] && tag_len_q[i] == len_q && tag_key_q[i] == key_q) begin
        hit_found = 1'b1;
        hit_idx   = SLOT_W'(i);
      end
      if (!inv_found && !valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = SLOT_W'(i);
      end
    end
    // SLOT_W-bit addition wraps naturally because NUM_SLOTS is a power of 2.
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand = rr_q + SLOT_W'(k);
      if (!ev_found && !pin_i[cand]) begin
        ev_found = 1'b1;
        ev_idx   = cand;
      end
    end
    victim_ok  = inv_found || ev_found;
    victim_sel = inv_found ? inv_idx : ev_idx;
  end

  logic [3:0] n_sub;
  logic       wr_ok, fill_done, accept, do_flush;

  assign n_sub     = num_subkeys(len_q);
  assign wr_ok     = (state_q == S_COLLECT) && bus.exp_valid && (bus.exp_waddr < n_sub);
  assign fill_done = wr_ok && ((cnt_q + 4'd1) == n_sub);
  assign do_flush  = (state_q == S_IDLE) && flush_i;
  assign accept    = (state_q == S_IDLE) && !flush_i && bus.req_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (len_q == 2'b00)  state_d = S_RESP;
        else if (hit_found)  state_d = S_RESP;
        else if (victim_ok)  state_d = S_START;
        // otherwise every slot is valid and pinned: re-evaluate next cycle
      end
      S_START:   state_d = S_COLLECT;
      S_COLLECT: if (fill_done) state_d = S_RESP;
      S_RESP:    if (bus.resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q       <= '0;
      len_q       <= '0;
      valid_q     <= '0;
      rr_q        <= '0;
      victim_q    <= '0;
      resp_slot_q <= '0;
      resp_hit_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      if (do_flush) valid_q <= '0;
      if (accept) begin
        key_q <= mask_key(bus.req_key, bus.req_len);
        len_q <= bus.req_len;
      end
      if (state_q == S_LOOKUP) begin
        if (len_q == 2'b00) begin
          resp_err_q <= 1'b1;
          resp_hit_q <= 1'b0;
        end else if (hit_found) begin
          resp_hit_q  <= 1'b1;
          resp_slot_q <= hit_idx;
        end else if (victim_ok) begin
          // Invalidate now so an interrupted fill never looks valid.
          valid_q[victim_sel] <= 1'b0;
          rr_q                <= victim_sel + 1'b1;
          victim_q            <= victim_sel;
          cnt_q               <= '0;
        end
      end
      if (wr_ok) cnt_q <= cnt_q + 4'd1;
      if (fill_done) begin
        valid_q[victim_q] <= 1'b1;
        resp_hit_q        <= 1'b0;
        resp_slot_q       <= victim_q;
      end
      if (state_q == S_RESP && bus.resp_ready) resp_err_q <= 1'b0;
      if (bus.rd_en) rd_data_q <= mem_q[bus.rd_slot][bus.rd_idx];
    end
  end

  // Round-key storage and tags carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[victim_q][bus.exp_waddr] <= bus.exp_subkey;
    if (fill_done) begin
      tag_key_q[victim_q] <= key_q;
      tag_len_q[victim_q] <= len_q;
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) && !flush_i;
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_slot  = resp_slot_q;
    bus.resp_hit   = resp_hit_q;
    bus.resp_err   = resp_err_q;
    bus.exp_start  = (state_q == S_START);
    bus.exp_key    = key_q;
    bus.exp_len    = len_q;
    bus.rd_data    = rd_data_q;
    busy_o         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_key_sched_cache.sv
// tb/tb_key_sched_cache.sv - scoreboard bench for key_sched_cache

module tb_key_sched_cache;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pin;
  logic       flush;
  logic       busy;

  always #5 clk = ~clk;

  key_sched_cache_if #(.KEY_W(256), .SUBKEY_W(128), .SLOT_W(2)) bus ();

  key_sched_cache #(
    .NUM_SLOTS(4), .SLOT_W(2), .KEY_W(256), .SUBKEY_W(128), .RK_DEPTH(15)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pin_i  (pin),
    .flush_i(flush),
    .busy_o (busy),
    .bus    (bus)
  );

  localparam logic [127:0] FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [255:0] K1   = {FIPS, 128'h11111111_11111111_11111111_11111111};
  localparam logic [255:0] K1B  = {FIPS, 128'h22222222_22222222_22222222_22222222};
  localparam logic [255:0] K2   = {FIPS, 128'h33333333_33333333_44444444_44444444};
  localparam logic [255:0] K2M  = {FIPS, 128'h33333333_33333333_00000000_00000000};
  localparam logic [255:0] K3   = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
  localparam logic [255:0] K4   = 256'hcafef00d_12345678_9abcdef0_0fedcba9_a5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  localparam logic [255:0] K5   = {128'h55555555_66666666_77777777_88888888, 128'h0};
  localparam logic [255:0] K6   = {128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc, 128'h0};
  localparam logic [255:0] K7   = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  typedef struct packed {
    logic [1:0] slot;
    logic       hit;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  int   eng_beats = 0;
  int   eng_limit = 0;

  function automatic void check(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // Engine subkey model: arbitrary but deterministic, except the known AES-128
  // last round key for the FIPS-197 example key.
  function automatic logic [127:0] sk(input logic [255:0] k, input logic [1:0] l, input logic [3:0] i);
    if (k[255:128] == FIPS && l == 2'b01 && i == 4'd10)
      return 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    return k[255:128] ^ k[127:0] ^ {l, 122'd0, i};
  endfunction

  function automatic int nsub(input logic [1:0] l);
    return (l == 2'b01) ? 11 : (l == 2'b10) ? 13 : 15;
  endfunction

  // Monitor: counts start pulses and checks every accepted response against the queue.
  always @(negedge clk) begin
    if (bus.exp_start) n_start++;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got slot %0d with no expected response", bus.resp_slot);
      end else begin
        mon_e = sb.pop_front();
        check("resp_err", 256'(bus.resp_err), 256'(mon_e.err));
        if (!mon_e.err) begin
          check("resp_hit", 256'(bus.resp_hit), 256'(mon_e.hit));
          check("resp_slot", 256'(bus.resp_slot), 256'(mon_e.slot));
        end
      end
    end
  end

  // Expansion engine model: one out-of-range beat, then subkeys 0..N-1.
  logic [255:0] ek;
  logic [1:0]   el;
  int           en;
  initial begin
    bus.exp_valid  = 1'b0;
    bus.exp_waddr  = '0;
    bus.exp_subkey = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.exp_start) begin
        ek = bus.exp_key;
        el = bus.exp_len;
        en = nsub(el);
        eng_beats = 0;
        for (int i = -1; i < en; i++) begin
          if (eng_limit != 0 && eng_beats >= eng_limit) break;
          @(posedge clk); #1;
          bus.exp_valid  = 1'b1;
          bus.exp_waddr  = (i < 0) ? 4'(en) : 4'(i);
          bus.exp_subkey = (i < 0) ? {4{32'hdeadbeef}} : sk(ek, el, 4'(i));
          eng_beats++;
        end
        @(posedge clk); #1;
        bus.exp_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [255:0] k, input logic [1:0] l, input logic [1:0] s, input logic h);
    exp_t x;
    int   w;
    x.slot = s;
    x.hit  = h;
    x.err  = (l == 2'b00);
    sb.push_back(x);
    bus.req_key   = k;
    bus.req_len   = l;
    bus.req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_accept: req_ready stayed 0 for %0d cycles, required 1", w);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 400);
    if (!bus.resp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: resp_valid 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic finish_resp(output int n);
    wait_valid(n);
    tick();
  endtask

  task automatic rd(input logic [1:0] s, input logic [3:0] i, output logic [127:0] d);
    bus.rd_en   = 1'b1;
    bus.rd_slot = s;
    bus.rd_idx  = i;
    tick();
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ctl"}, 256'({bus.req_ready, bus.resp_valid, busy, bus.exp_start, bus.exp_len,
                              bus.resp_slot, bus.resp_hit, bus.resp_err}), 256'(10'b1000000000));
    check({nm, "_exp_key"}, bus.exp_key, 256'd0);
    check({nm, "_rd_data"}, 256'(bus.rd_data), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           n;
    int           w;
    logic [127:0] d;

    rst_n          = 1'b0;
    pin            = 4'b0000;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_key    = '0;
    bus.req_len    = 2'b00;
    bus.resp_ready = 1'b1;
    bus.rd_en      = 1'b0;
    bus.rd_slot    = '0;
    bus.rd_idx     = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 128-bit miss into slot 0
    issue(K1, 2'b01, 2'd0, 1'b0);
    finish_resp(n);
    check("t1_starts", 256'(n_start), 256'd1);
    check("t1_exp_key", bus.exp_key, {FIPS, 128'h0});
    check("t1_exp_len", 256'(bus.exp_len), 256'd1);
    rd(2'd0, 4'd10, d);
    check("t1_rk10", 256'(d), 256'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));

    // Same top 128 bits, different low bits: hit with 2-cycle latency
    issue(K1B, 2'b01, 2'd0, 1'b1);
    finish_resp(n);
    check("t2_latency", 256'(n), 256'd2);
    check("t2_starts", 256'(n_start), 256'd1);

    // Same top bits, 192-bit length: miss into slot 1, slot 0 still hits
    issue(K2, 2'b10, 2'd1, 1'b0);
    finish_resp(n);
    check("t3_starts", 256'(n_start), 256'd2);
    check("t3_exp_key", bus.exp_key, K2M);
    rd(2'd1, 4'd12, d);
    check("t3_rk12", 256'(d), 256'(sk(K2M, 2'b10, 4'd12)));
    rd(2'd0, 4'd10, d);
    check("t3_slot0_rk10", 256'(d), 256'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
    issue(K1, 2'b01, 2'd0, 1'b1);
    finish_resp(n);

    // Fill slots 2 and 3, then evict around a pinned slot
    issue(K3, 2'b11, 2'd2, 1'b0);
    finish_resp(n);
    issue(K4, 2'b11, 2'd3, 1'b0);
    finish_resp(n);
    rd(2'd2, 4'd14, d);
    check("t4_slot2_rk14", 256'(d), 256'(sk(K3, 2'b11, 4'd14)));
    pin = 4'b0001;
    issue(K5, 2'b01, 2'd1, 1'b0);
    finish_resp(n);
    pin = 4'b1111;
    issue(K6, 2'b01, 2'd0, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_stall", 256'({bus.resp_valid, busy}), 256'(2'b01));
    check("t4_stall_starts", 256'(n_start), 256'd5);
    tick();
    pin = 4'b1110;
    finish_resp(n);
    pin = 4'b0000;
    check("t4_starts", 256'(n_start), 256'd6);

    // Illegal length: error response held until resp_ready
    bus.resp_ready = 1'b0;
    issue(K1, 2'b00, 2'd0, 1'b0);
    wait_valid(n);
    repeat (3) @(negedge clk);
    check("t5_hold", 256'({bus.resp_valid, bus.resp_err}), 256'(2'b11));
    tick();
    bus.resp_ready = 1'b1;
    tick();
    check("t5_err_cleared", 256'({bus.resp_valid, bus.resp_err}), 256'(2'b00));
    check("t5_starts", 256'(n_start), 256'd6);

    // Cached key hits, then flush and the same key misses
    issue(K5, 2'b01, 2'd1, 1'b1);
    finish_resp(n);
    flush = 1'b1;
    @(negedge clk);
    check("t5_flush_ready", 256'(bus.req_ready), 256'd0);
    tick();
    flush = 1'b0;
    issue(K5, 2'b01, 2'd0, 1'b0);
    finish_resp(n);
    check("t5_flush_starts", 256'(n_start), 256'd7);

    // Reset in the middle of a 256-bit fill
    eng_limit = 5;
    eng_beats = 0;
    issue(K7, 2'b11, 2'd1, 1'b0);
    w = 0;
    while (eng_beats < 5 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("t6_beats", 256'(eng_beats), 256'd5);
    tick();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    eng_limit = 0;
    tick();
    issue(K7, 2'b11, 2'd0, 1'b0);
    finish_resp(n);
    check("t6_starts", 256'(n_start), 256'd9);
    rd(2'd0, 4'd14, d);
    check("t6_rk14", 256'(d), 256'(sk(K7, 2'b11, 4'd14)));
    rd(2'd0, 4'd0, d);
    check("t6_rk0", 256'(d), 256'(sk(K7, 2'b11, 4'd0)));

    repeat (3) @(negedge clk);
    check("sb_drained", 256'(sb.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
